output_packer: RTL and testbench
================================

# output_packer

Downstream stage of the decompressor wrapper: consumes its 512-bit output beats with their per-byte valid mask and repacks the valid bytes into dense 64-byte words for the host write-back path. The block counts bytes against the job's decompressed length, drops anything beyond it, marks the final (possibly partial) word with `out_last`, and pulses `done` when that word is taken. It sits between the decompressor's `out_data`/`out_data_valid`/`out_data_byte_valid` outputs and the memory-write master.

## Interface
- `DATA_W`, 512: data width in bits; `BYTES = DATA_W/8 = 64`.
- `LEN_W`, 32: job byte-length width.

- `clk`  in  1  the single clock.
- `rst`  in  1  reset, synchronous, active-high.
- `total_length`  in  LEN_W  decompressed job length in bytes.
- `total_length_valid` / `total_length_ready`  in / out  1  metadata handshake.
- `in_data`  in  DATA_W  decompressed data, byte 0 in bits [7:0].
- `in_byte_valid`  in  BYTES  valid-byte mask; must be a contiguous prefix from bit 0.
- `in_valid` / `in_ready`  in / out  1  input handshake.
- `out_data`  out  DATA_W  packed data.
- `out_byte_count`  out  7  valid bytes in `out_data` (1..64).
- `out_last`  out  1  final word of the job.
- `out_valid` / `out_ready`  out / in  1  output handshake.
- `done`  out  1  one-cycle pulse at job end.
- `overrun_err`, `mask_err`  out  1  sticky error flags, cleared on metadata accept.

## Operation
- States: IDLE, RUN, FLUSH, END.
- IDLE: `total_length_ready`=1, `in_ready`=0. On accept, `remaining <= total_length`, `fill <= 0`, errors cleared. Go to RUN, or to END if `total_length`=0.
- RUN: `in_ready = !out_valid || out_ready`. On an accepted beat:
  - `n = popcount(in_byte_valid)`, `n_eff = min(n, remaining)`. If `n > remaining`, set `overrun_err`.
  - If the mask is not a prefix, set `mask_err` and still use `n` (bytes at positions 0..n-1).
  - Merge: `comb = hold | (in_data << 8*fill)` (128-byte wide), `sum = fill + n_eff`.
  - If `sum >= 64`: load the output register with `comb[511:0]`, `out_byte_count=64`; hold takes `comb[1023:512]`, `fill <= sum-64`. Set `out_last` when `remaining-n_eff==0` and `sum==64`.
  - Otherwise: `hold <= comb[511:0]`, `fill <= sum`.
  - `remaining -= n_eff`. When it reaches 0: go to FLUSH if `fill_new>0`; else go to END once the last word handshakes.
- FLUSH: `in_ready`=0. When the output register is free or draining, load `hold` with `out_byte_count=fill`, `out_last=1`, `fill<=0`. Go to END.
- END: wait for the `out_last` handshake, or 1 cycle for a zero-length job. Pulse `done`, return to IDLE.
- Beats arriving outside RUN are not accepted.
- Bytes of the output word at positions ≥ `out_byte_count` are don't-care. The bench drives them to zero for checking.

## Timing
- Reset values:
  - `total_length_ready`=1.
  - `in_ready`, `out_valid`, `out_last`, `done`, `overrun_err`, `mask_err` = 0.
  - `out_data`=0, `out_byte_count`=0, `fill`=0, `remaining`=0, state IDLE.
- Latency: an input beat that completes 64 bytes produces `out_valid` on the next cycle.
- Output register holds data and count stable while `out_valid && !out_ready`.
- A simultaneous output drain and input accept is allowed, giving full throughput of 1 word/cycle.
- `done` asserts in the cycle after the `out_last` handshake. For a zero-length job it asserts 1 cycle after the metadata accept. It lasts exactly one cycle.
- Next metadata is accepted no earlier than the cycle after `done`.
- `rst` mid-job returns everything to reset values in the next cycle. In-flight data is discarded.

## Structure
- Shared package `packer_pkg`:
  - `BYTES`, `CNT_W=7`.
  - State enum.
  - Functions `popcount64` and `is_prefix_mask`.
- One sub-module `pack_shifter`: combinational 128-byte merge `hold | (data << 8*fill)`, `fill` in 0..63. Keeps the barrel shifter separately timed and testable.

## Test plan
- Length 128, two all-ones beats → two output words (bytes 0..63, then 64..127), count 64 each, second with `out_last`; `done` pulses once.
- Length 100, beats of 40/40/20 bytes → word 1 = input bytes 0..63 (count 64); word 2 = bytes 64..99, count 36, `out_last`.
- Length 256, `out_ready` low for 10 cycles mid-stream → `in_ready` drops within 1 cycle; the output stream is byte-exact with no loss or duplication.
- Length 10, one beat with 64 valid bytes → one word, count 10, `out_last`, `overrun_err`=1.
- Length 0 → no output word; `done` pulses 1 cycle after the metadata accept. Mask `0x...F0F` on any beat → `mask_err`=1.
- `rst` asserted mid-job (after 1 of 3 words) → all outputs reach reset values; a following length-64 job completes cleanly with errors clear.

Source files
------------

// File: rtl/output_packer_pkg.sv
// Shared definitions for the output packer: byte/count widths, FSM state
// type and the byte-mask helpers.
package packer_pkg;

  localparam int unsigned BYTES  = 64;
  localparam int unsigned CNT_W  = 7;
  localparam int unsigned FILL_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH,
    ST_END
  } state_t;

  function automatic logic [CNT_W-1:0] popcount64(input logic [BYTES-1:0] m);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < BYTES; i++) begin
      c = c + CNT_W'(m[i]);
    end
    return c;
  endfunction

  // A contiguous run of ones from bit 0 turns into a single carry when
  // incremented, so it shares no set bit with its successor.
  function automatic logic is_prefix_mask(input logic [BYTES-1:0] m);
    return (m & (m + {{(BYTES-1){1'b0}}, 1'b1})) == '0;
  endfunction

endpackage

// File: rtl/output_packer_if.sv
// Bus bundle of the output packer: job metadata handshake, decompressed
// input beats, packed output words and status.
//   slave  : the packer side
//   master : the upstream/downstream environment side
interface output_packer_if
  import packer_pkg::*;
#(
  parameter int unsigned DATA_W = 512,
  parameter int unsigned LEN_W  = 32
);

  logic [LEN_W-1:0]    total_length;
  logic                total_length_valid;
  logic                total_length_ready;
  logic [DATA_W-1:0]   in_data;
  logic [DATA_W/8-1:0] in_byte_valid;
  logic                in_valid;
  logic                in_ready;
  logic [DATA_W-1:0]   out_data;
  logic [CNT_W-1:0]    out_byte_count;
  logic                out_last;
  logic                out_valid;
  logic                out_ready;
  logic                done;
  logic                overrun_err;
  logic                mask_err;

  modport slave (
    input  total_length, total_length_valid,
    input  in_data, in_byte_valid, in_valid,
    input  out_ready,
    output total_length_ready, in_ready,
    output out_data, out_byte_count, out_last, out_valid,
    output done, overrun_err, mask_err
  );

  modport master (
    output total_length, total_length_valid,
    output in_data, in_byte_valid, in_valid,
    output out_ready,
    input  total_length_ready, in_ready,
    input  out_data, out_byte_count, out_last, out_valid,
    input  done, overrun_err, mask_err
  );

endinterface

// File: rtl/output_packer_shifter.sv
// pack_shifter: combinational 128-byte merge of the partial-word hold
// register with a new beat placed at byte offset i_fill.
//   i_hold : bytes already held (bytes >= i_fill are zero)
//   i_data : new beat, already masked to its effective bytes
//   i_fill : byte offset 0..63
//   o_comb : hold | (data << 8*fill), 2*DATA_W bits
module pack_shifter
  import packer_pkg::*;
#(
  parameter int unsigned DATA_W = 512
) (
  input  logic [DATA_W-1:0]   i_hold,
  input  logic [DATA_W-1:0]   i_data,
  input  logic [FILL_W-1:0]   i_fill,
  output logic [2*DATA_W-1:0] o_comb
);

  logic [2*DATA_W-1:0] w_data_ext;
  logic [FILL_W+2:0]   w_shamt;

  always_comb begin
    w_data_ext = {{DATA_W{1'b0}}, i_data};
    w_shamt    = {i_fill, 3'b000};
    o_comb     = {{DATA_W{1'b0}}, i_hold} | (w_data_ext << w_shamt);
  end

endmodule

// File: rtl/output_packer.sv
// output_packer: repacks valid bytes of decompressor beats into dense
// 64-byte words, truncates at the job length, flags the final word with
// out_last and pulses done once it is taken.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of output_packer_if (metadata, input beats,
//              packed output words, done and sticky error flags)
module output_packer
  import packer_pkg::*;
#(
  parameter int unsigned DATA_W = 512,
  parameter int unsigned LEN_W  = 32
) (
  input logic            clk,
  input logic            rst,
  output_packer_if.slave bus
);

  state_t              r_state;
  logic [LEN_W-1:0]    r_remaining;
  logic [FILL_W-1:0]   r_fill;
  logic [DATA_W-1:0]   r_hold;
  logic [DATA_W-1:0]   r_out_data;
  logic [CNT_W-1:0]    r_out_cnt;
  logic                r_out_valid;
  logic                r_out_last;
  logic                r_done;
  logic                r_ovr_err;
  logic                r_mask_err;

  logic                w_drain;
  logic                w_out_free;
  logic                w_in_ready;
  logic                w_beat_fire;
  logic                w_overrun;
  logic                w_full;
  logic [CNT_W-1:0]    w_n;
  logic [CNT_W-1:0]    w_n_eff;
  logic [CNT_W-1:0]    w_sum;
  logic [LEN_W-1:0]    w_rem_next;
  logic [DATA_W-1:0]   w_data_m;
  logic [2*DATA_W-1:0] w_comb;

  always_comb begin
    w_drain     = r_out_valid && bus.out_ready;
    w_out_free  = !r_out_valid || bus.out_ready;
    w_in_ready  = (r_state == ST_RUN) && w_out_free;
    w_beat_fire = w_in_ready && bus.in_valid;
    w_n         = popcount64(bus.in_byte_valid);
    w_overrun   = LEN_W'(w_n) > r_remaining;
    w_n_eff     = w_overrun ? CNT_W'(r_remaining) : w_n;
    w_sum       = CNT_W'(r_fill) + w_n_eff;
    w_full      = w_sum >= CNT_W'(BYTES);
    w_rem_next  = r_remaining - LEN_W'(w_n_eff);
    // Zero everything past the effective byte count so the hold register
    // stays zero above its fill level and the OR-merge never picks up
    // stale or beyond-length bytes.
    w_data_m = '0;
    for (int unsigned i = 0; i < BYTES; i++) begin
      if (CNT_W'(i) < w_n_eff) w_data_m[8*i +: 8] = bus.in_data[8*i +: 8];
    end
  end

  pack_shifter #(.DATA_W(DATA_W)) u_shift (
    .i_hold (r_hold),
    .i_data (w_data_m),
    .i_fill (r_fill),
    .o_comb (w_comb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_remaining <= '0;
      r_fill      <= '0;
      r_hold      <= '0;
      r_out_data  <= '0;
      r_out_cnt   <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_done      <= 1'b0;
      r_ovr_err   <= 1'b0;
      r_mask_err  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_drain) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (bus.total_length_valid) begin
            r_remaining <= bus.total_length;
            r_fill      <= '0;
            r_hold      <= '0;
            r_ovr_err   <= 1'b0;
            r_mask_err  <= 1'b0;
            if (bus.total_length == '0) begin
              r_done  <= 1'b1;
              r_state <= ST_END;
            end else begin
              r_state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (w_beat_fire) begin
            if (w_overrun) r_ovr_err <= 1'b1;
            if (!is_prefix_mask(bus.in_byte_valid)) r_mask_err <= 1'b1;
            if (w_full) begin
              r_out_data  <= w_comb[DATA_W-1:0];
              r_out_cnt   <= CNT_W'(BYTES);
              r_out_valid <= 1'b1;
              r_out_last  <= (w_rem_next == '0) && (w_sum == CNT_W'(BYTES));
              r_hold      <= w_comb[2*DATA_W-1:DATA_W];
            end else begin
              r_hold      <= w_comb[DATA_W-1:0];
            end
            // sum < 128, so the low bits are the new fill in both cases.
            r_fill      <= w_sum[FILL_W-1:0];
            r_remaining <= w_rem_next;
            if (w_rem_next == '0) begin
              r_state <= (w_sum[FILL_W-1:0] != '0) ? ST_FLUSH : ST_END;
            end
          end
        end
        ST_FLUSH: begin
          if (w_out_free) begin
            r_out_data  <= r_hold;
            r_out_cnt   <= CNT_W'(r_fill);
            r_out_valid <= 1'b1;
            r_out_last  <= 1'b1;
            r_fill      <= '0;
            r_hold      <= '0;
            r_state     <= ST_END;
          end
        end
        ST_END: begin
          // Stay here while done is high so new metadata waits a cycle.
          if (r_done) begin
            r_state <= ST_IDLE;
          end else if (w_drain && r_out_last) begin
            r_done <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.total_length_ready = (r_state == ST_IDLE);
  assign bus.in_ready           = w_in_ready;
  assign bus.out_data           = r_out_data;
  assign bus.out_byte_count     = r_out_cnt;
  assign bus.out_last           = r_out_last;
  assign bus.out_valid          = r_out_valid;
  assign bus.done               = r_done;
  assign bus.overrun_err        = r_ovr_err;
  assign bus.mask_err           = r_mask_err;

endmodule

// File: tb/tb_output_packer.sv
// Self-checking bench for output_packer: random beats and back-pressure
// against a byte-stream reference model.
module tb_output_packer;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  output_packer_if #(.DATA_W(512), .LEN_W(32)) bus ();

  output_packer #(.DATA_W(512), .LEN_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [511:0] beat_d[$];
  logic [63:0]  beat_m[$];
  logic [7:0]   exp_q[$];
  int unsigned  job_len;
  int unsigned  taken;
  bit           exp_ovr;
  bit           exp_mask;

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.total_length       = '0;
    bus.total_length_valid = 1'b0;
    bus.in_data            = '0;
    bus.in_byte_valid      = '0;
    bus.in_valid           = 1'b0;
    bus.out_ready          = 1'b0;
  endtask

  task automatic check_reset();
    check_eq("rst_tl_ready", bus.total_length_ready, 1);
    check_eq("rst_in_ready", bus.in_ready, 0);
    check_eq("rst_out_valid", bus.out_valid, 0);
    check_eq("rst_out_last", bus.out_last, 0);
    check_eq("rst_done", bus.done, 0);
    check_eq("rst_overrun", bus.overrun_err, 0);
    check_eq("rst_mask", bus.mask_err, 0);
    check_eq("rst_out_data", bus.out_data, 0);
    check_eq("rst_out_cnt", bus.out_byte_count, 0);
  endtask

  task automatic new_job(input int unsigned len);
    beat_d.delete();
    beat_m.delete();
    exp_q.delete();
    job_len  = len;
    taken    = 0;
    exp_ovr  = 1'b0;
    exp_mask = 1'b0;
  endtask

  // Model: a beat contributes its first n bytes to the job's byte stream;
  // bytes past the job length are dropped and flag an overrun.
  task automatic add_beat(input int unsigned n, input bit bad);
    logic [511:0] d;
    logic [63:0]  m;
    d = '0;
    for (int unsigned k = 0; k < n; k++) d[8*k +: 8] = 8'($urandom);
    if (bad) begin
      m = 64'h0F0F;
      exp_mask = 1'b1;
    end else if (n >= 64) begin
      m = '1;
    end else begin
      m = (64'd1 << n) - 64'd1;
    end
    for (int unsigned k = 0; k < n; k++) begin
      if (taken < job_len) begin
        exp_q.push_back(d[8*k +: 8]);
        taken++;
      end else begin
        exp_ovr = 1'b1;
      end
    end
    beat_d.push_back(d);
    beat_m.push_back(m);
  endtask

  task automatic add_random_beats();
    while (taken < job_len) add_beat($urandom_range(0, 64), 1'b0);
  endtask

  task automatic compare_word(output bit exp_last);
    int unsigned  cnt;
    logic [511:0] ew;
    logic [511:0] aw;
    ew  = '0;
    aw  = '0;
    cnt = (exp_q.size() < 64) ? exp_q.size() : 64;
    for (int unsigned k = 0; k < cnt; k++) begin
      ew[8*k +: 8] = exp_q.pop_front();
      aw[8*k +: 8] = bus.out_data[8*k +: 8];
    end
    exp_last = (exp_q.size() == 0);
    check_eq("out_count", bus.out_byte_count, cnt);
    check_eq("out_last", bus.out_last, exp_last);
    check_eq("out_data", aw, ew);
  endtask

  task automatic run_job(input bit stall, input int unsigned abort_words);
    int unsigned  bi;
    int unsigned  words;
    int unsigned  stall_left;
    int unsigned  cyc;
    bit           prev_last;
    bit           prev_hold;
    bit           done_seen;
    bit           aborted;
    bit           el;
    logic [511:0] prev_data;
    logic [6:0]   prev_cnt;
    bi = 0; words = 0; stall_left = 0; cyc = 0;
    prev_last = (job_len == 0);
    prev_hold = 1'b0; done_seen = 1'b0; aborted = 1'b0;
    prev_data = '0; prev_cnt = '0;

    @(negedge clk);
    bus.total_length       = job_len;
    bus.total_length_valid = 1'b1;
    #1;
    check_eq("meta_ready", bus.total_length_ready, 1);

    while (!done_seen && !aborted && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      bus.total_length_valid = 1'b0;
      if (stall_left > 0) begin
        bus.out_ready = 1'b0;
        stall_left--;
      end else begin
        bus.out_ready = ($urandom_range(0, 3) != 0);
      end
      if (bi < beat_d.size()) begin
        bus.in_valid      = 1'b1;
        bus.in_data       = beat_d[bi];
        bus.in_byte_valid = beat_m[bi];
      end else begin
        bus.in_valid      = 1'b0;
        bus.in_data       = '0;
        bus.in_byte_valid = '0;
      end
      #1;
      check_eq("done_pulse", bus.done, prev_last);
      if (bus.done) begin
        done_seen = 1'b1;
        check_eq("meta_blocked_at_done", bus.total_length_ready, 0);
      end
      if (prev_hold) begin
        check_eq("hold_data", bus.out_data, prev_data);
        check_eq("hold_cnt", bus.out_byte_count, prev_cnt);
      end
      if (bus.out_valid && !bus.out_ready) check_eq("backpressure", bus.in_ready, 0);
      prev_last = 1'b0;
      if (bus.out_valid && bus.out_ready) begin
        compare_word(el);
        prev_last = el;
        words++;
        if (stall && words == 1) stall_left = 10;
        if (abort_words != 0 && words == abort_words) aborted = 1'b1;
      end
      if (bus.in_valid && bus.in_ready) bi++;
      prev_hold = bus.out_valid && !bus.out_ready;
      prev_data = bus.out_data;
      prev_cnt  = bus.out_byte_count;
    end

    if (!aborted) begin
      check_eq("done_seen", done_seen, 1);
      check_eq("bytes_left", exp_q.size(), 0);
      check_eq("overrun_err", bus.overrun_err, exp_ovr);
      check_eq("mask_err", bus.mask_err, exp_mask);
      @(negedge clk);
      bus.out_ready = 1'b0;
      #1;
      check_eq("done_width", bus.done, 0);
      check_eq("meta_ready_after", bus.total_length_ready, 1);
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check_reset();
    rst = 1'b0;

    new_job(128);
    add_beat(64, 1'b0);
    add_beat(64, 1'b0);
    run_job(1'b0, 0);

    new_job(100);
    add_beat(40, 1'b0);
    add_beat(40, 1'b0);
    add_beat(20, 1'b0);
    run_job(1'b0, 0);

    new_job(256);
    add_random_beats();
    run_job(1'b1, 0);

    new_job(10);
    add_beat(64, 1'b0);
    run_job(1'b0, 0);

    new_job(0);
    run_job(1'b0, 0);

    new_job(30);
    add_beat(8, 1'b1);
    add_beat(22, 1'b0);
    run_job(1'b0, 0);

    repeat (12) begin
      new_job($urandom_range(1, 400));
      if ($urandom_range(0, 3) == 0 && job_len >= 8) add_beat(8, 1'b1);
      add_random_beats();
      run_job($urandom_range(0, 1) == 1, 0);
    end

    // Abort a three-word job after its first word, then run a clean job.
    new_job(192);
    add_beat(8, 1'b1);
    add_beat(64, 1'b0);
    add_beat(64, 1'b0);
    add_beat(64, 1'b0);
    run_job(1'b0, 1);
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    #1;
    check_reset();
    rst = 1'b0;
    new_job(64);
    add_beat(64, 1'b0);
    run_job(1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
